mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM load/store requests into lane-masked,
// word-aligned data-memory accesses, aligns and extends load data, flags
// misaligned addresses and registers the outcome into the MEM/WB stage.
module mem_access_unit #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [4:0]  EXC_ADEL = 5'd4,
    parameter logic [4:0]  EXC_ADES = 5'd5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_rd,
    input  logic              ex_wr,
    input  logic [1:0]        ex_size,
    input  logic              ex_sext,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [31:0]       ex_alu_res,
    input  logic [4:0]        ex_wreg,
    input  logic [31:0]       ex_pc,
    input  logic              stall,
    input  logic              flush,
    output logic              dm_en,
    output logic [3:0]        dm_byte,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_in,
    input  logic [31:0]       dm_out,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_wreg,
    output logic [31:0]       wb_wdata,
    output logic              exc_valid,
    output logic [4:0]        exc_code,
    output logic [ADDR_W-1:0] exc_badvaddr,
    output logic [31:0]       exc_epc
);

    logic [1:0]  off;
    logic        is_byte;
    logic        is_half;
    logic        mem_op;
    logic        mis;
    logic        go;
    logic        live;
    logic        fault;
    logic        load;
    logic [3:0]  lane_mask;
    logic [31:0] store_rep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    logic              wb_valid_q,  wb_valid_d;
    logic              wb_we_q,     wb_we_d;
    logic [4:0]        wb_wreg_q,   wb_wreg_d;
    logic [31:0]       wb_wdata_q,  wb_wdata_d;
    logic              exc_valid_q, exc_valid_d;
    logic [4:0]        exc_code_q,  exc_code_d;
    logic [ADDR_W-1:0] exc_bad_q,   exc_bad_d;
    logic [31:0]       exc_epc_q,   exc_epc_d;

    // Decode access size, alignment and whether the slot advances this cycle.
    // Alignment only matters for memory ops, so ALU slots never fault.
    always_comb begin
        off     = ex_addr[1:0];
        is_byte = (ex_size == 2'b00);
        is_half = (ex_size == 2'b01);
        mem_op  = ex_rd | ex_wr;
        mis     = mem_op & ((is_half & off[0]) |
                            (~is_byte & ~is_half & (off != 2'b00)));
        go      = ex_valid & ~flush & ~stall;
        live    = go & ~mis;
        fault   = go & mis;
        load    = ex_rd & ~ex_wr;
    end

    // Drive the data memory: word-aligned address, lane mask and replicated store data.
    always_comb begin
        dm_en   = live & mem_op;
        dm_addr = {ex_addr[ADDR_W-1:2], 2'b00};
        if (is_byte) begin
            lane_mask = 4'b0001 << off;
            store_rep = {4{ex_wdata[7:0]}};
        end else if (is_half) begin
            lane_mask = 4'b0011 << off;
            store_rep = {2{ex_wdata[15:0]}};
        end else begin
            lane_mask = 4'b1111;
            store_rep = ex_wdata;
        end
        dm_byte = '0;
        dm_in   = '0;
        if (dm_en) begin
            dm_in = store_rep;
            if (ex_wr) begin
                dm_byte = lane_mask;
            end
        end
    end

    // Select the addressed byte/half from the read word and zero- or sign-extend it.
    always_comb begin
        case (off)
            2'd0:    ld_byte = dm_out[7:0];
            2'd1:    ld_byte = dm_out[15:8];
            2'd2:    ld_byte = dm_out[23:16];
            default: ld_byte = dm_out[31:24];
        endcase
        ld_half   = off[1] ? dm_out[31:16] : dm_out[15:0];
        load_data = dm_out;
        if (is_byte) begin
            load_data = {{24{ex_sext & ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            load_data = {{16{ex_sext & ld_half[15]}}, ld_half};
        end
    end

    // Next MEM/WB and exception state; bubbles keep wreg/wdata and exception info.
    always_comb begin
        wb_valid_d  = live;
        wb_we_d     = live & ~ex_wr;
        wb_wreg_d   = wb_wreg_q;
        wb_wdata_d  = wb_wdata_q;
        exc_valid_d = fault;
        exc_code_d  = exc_code_q;
        exc_bad_d   = exc_bad_q;
        exc_epc_d   = exc_epc_q;
        if (live) begin
            wb_wreg_d  = ex_wreg;
            wb_wdata_d = load ? load_data : ex_alu_res;
        end
        if (fault) begin
            exc_code_d = ex_wr ? EXC_ADES : EXC_ADEL;
            exc_bad_d  = ex_addr;
            exc_epc_d  = ex_pc;
        end
    end

    // MEM/WB pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_wreg_q   <= '0;
            wb_wdata_q  <= '0;
            exc_valid_q <= 1'b0;
            exc_code_q  <= '0;
            exc_bad_q   <= '0;
            exc_epc_q   <= '0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_wdata_q  <= wb_wdata_d;
            exc_valid_q <= exc_valid_d;
            exc_code_q  <= exc_code_d;
            exc_bad_q   <= exc_bad_d;
            exc_epc_q   <= exc_epc_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_we        = wb_we_q;
    assign wb_wreg      = wb_wreg_q;
    assign wb_wdata     = wb_wdata_q;
    assign exc_valid    = exc_valid_q;
    assign exc_code     = exc_code_q;
    assign exc_badvaddr = exc_bad_q;
    assign exc_epc      = exc_epc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed load/store scenarios plus a randomized
// stream checked against a byte-array reference model of memory and MEM/WB.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ex_valid, ex_rd, ex_wr, ex_sext, stall, flush;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata, ex_alu_res, ex_pc;
    logic [4:0]  ex_wreg;
    logic        dm_en, wb_valid, wb_we, exc_valid;
    logic [3:0]  dm_byte;
    logic [31:0] dm_addr, dm_in, dm_out, wb_wdata, exc_badvaddr, exc_epc;
    logic [4:0]  wb_wreg, exc_code;

    mem_access_unit #(.ADDR_W(32), .EXC_ADEL(5'd4), .EXC_ADES(5'd5)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr),
        .ex_size(ex_size), .ex_sext(ex_sext), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_alu_res(ex_alu_res), .ex_wreg(ex_wreg), .ex_pc(ex_pc), .stall(stall),
        .flush(flush), .dm_en(dm_en), .dm_byte(dm_byte), .dm_addr(dm_addr),
        .dm_in(dm_in), .dm_out(dm_out), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .exc_valid(exc_valid),
        .exc_code(exc_code), .exc_badvaddr(exc_badvaddr), .exc_epc(exc_epc)
    );

    // Byte-lane data memory seen by the DUT (16 words, addresses 0..63).
    logic [31:0] dm_mem [0:15] = '{default: '0};
    assign dm_out = dm_mem[dm_addr[5:2]];
    always @(posedge clk) begin
        if (dm_en) begin
            for (int k = 0; k < 4; k++) begin
                if (dm_byte[k]) dm_mem[dm_addr[5:2]][8*k +: 8] <= dm_in[8*k +: 8];
            end
        end
    end

    int wr_count = 0;
    always @(posedge clk) begin
        if (dm_en && dm_byte != 4'b0000) wr_count <= wr_count + 1;
    end

    // Reference model: byte-addressed memory and expected stage outputs.
    byte unsigned ref_mem [0:63];
    logic        m_valid, m_we, m_exc;
    logic [4:0]  m_wreg, m_code;
    logic [31:0] m_wdata, m_bad, m_epc;
    logic        e_dm_en;
    logic [3:0]  e_dm_byte;
    logic [31:0] e_dm_addr, e_dm_in;
    logic        o_dm_en;
    logic [3:0]  o_dm_byte;
    logic [31:0] o_dm_addr, o_dm_in;

    int checks = 0;
    int errors = 0;

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] alu, input logic [4:0] rg, input logic [31:0] pc);
        ex_valid = v; ex_rd = rd; ex_wr = wr; ex_size = sz; ex_sext = sx;
        ex_addr = a; ex_wdata = wd; ex_alu_res = alu; ex_wreg = rg; ex_pc = pc;
    endtask

    task automatic idle();
        set_op(1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
        stall = 1'b0; flush = 1'b0;
    endtask

    // One clock: predict from current inputs, capture dm drive mid-cycle,
    // then advance the model past the edge. Returns 1ns after the posedge.
    task automatic step();
        int n, idx;
        bit mem_op, mis, live, fault, load;
        logic [31:0] v;
        n      = (ex_size == 2'd0) ? 1 : (ex_size == 2'd1) ? 2 : 4;
        mem_op = ex_rd || ex_wr;
        mis    = mem_op && ((ex_addr % n) != 0);
        live   = ex_valid && !flush && !stall && !mis;
        fault  = ex_valid && !flush && !stall && mis;
        load   = ex_rd && !ex_wr;
        e_dm_en   = live && mem_op;
        e_dm_addr = ex_addr & ~32'h3;
        e_dm_byte = 4'b0000;
        e_dm_in   = 32'h0;
        if (e_dm_en) begin
            for (int k = 0; k < 4; k++) e_dm_in[8*k +: 8] = ex_wdata[8*(k % n) +: 8];
            if (ex_wr) for (int i = 0; i < n; i++) e_dm_byte[(ex_addr % 4) + i] = 1'b1;
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            idx = (int'(ex_addr[5:0]) + i) % 64;
            v = v | (32'(ref_mem[idx]) << (8*i));
        end
        if (ex_sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        @(negedge clk);
        o_dm_en = dm_en; o_dm_byte = dm_byte; o_dm_addr = dm_addr; o_dm_in = dm_in;
        @(posedge clk);
        if (e_dm_en && ex_wr) begin
            for (int i = 0; i < n; i++) begin
                idx = (int'(ex_addr[5:0]) + i) % 64;
                ref_mem[idx] = ex_wdata[8*i +: 8];
            end
        end
        if (rst) begin
            m_valid = 0; m_we = 0; m_wreg = 0; m_wdata = 0;
            m_exc = 0; m_code = 0; m_bad = 0; m_epc = 0;
        end else begin
            m_valid = live;
            m_we    = live && !ex_wr;
            if (live) begin
                m_wreg  = ex_wreg;
                m_wdata = load ? v : ex_alu_res;
            end
            m_exc = fault;
            if (fault) begin
                m_code = ex_wr ? 5'd5 : 5'd4;
                m_bad  = ex_addr;
                m_epc  = ex_pc;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        step(); step();
        checks++;
        if ({wb_valid, wb_we, wb_wreg, wb_wdata} !== 39'h0) begin
            errors++;
            $display("FAIL reset_wb: got v=%b we=%b rg=%0d wd=%h want all 0", wb_valid, wb_we, wb_wreg, wb_wdata);
        end
        checks++;
        if ({exc_valid, exc_code, exc_badvaddr, exc_epc} !== 70'h0) begin
            errors++;
            $display("FAIL reset_exc: got v=%b code=%0d bad=%h epc=%h want all 0", exc_valid, exc_code, exc_badvaddr, exc_epc);
        end
        rst = 1'b0;
    endtask

    task automatic test_word();
        idle();
        set_op(1, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 5'd1, 32'h100);
        step();
        checks++;
        if (o_dm_en !== 1'b1 || o_dm_byte !== 4'b1111 || o_dm_addr !== 32'h10 || o_dm_in !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_drive: got en=%b byte=%b addr=%h in=%h want 1 1111 10 deadbeef", o_dm_en, o_dm_byte, o_dm_addr, o_dm_in);
        end
        set_op(1, 1, 0, 2'd2, 0, 32'h10, 32'h0, 32'h0, 5'd3, 32'h104);
        step();
        checks++;
        if (wb_wdata !== 32'hDEADBEEF || wb_we !== 1'b1 || wb_valid !== 1'b1 || wb_wreg !== 5'd3) begin
            errors++;
            $display("FAIL lw: got wd=%h we=%b v=%b rg=%0d want deadbeef 1 1 3", wb_wdata, wb_we, wb_valid, wb_wreg);
        end
    endtask

    task automatic test_byte();
        set_op(1, 0, 1, 2'd0, 0, 32'h13, 32'h000000A5, 32'h0, 5'd0, 32'h108);
        step();
        checks++;
        if (o_dm_byte !== 4'b1000 || o_dm_in !== 32'hA5A5A5A5 || o_dm_addr !== 32'h10) begin
            errors++;
            $display("FAIL sb_drive: got byte=%b in=%h addr=%h want 1000 a5a5a5a5 10", o_dm_byte, o_dm_in, o_dm_addr);
        end
        set_op(1, 1, 0, 2'd0, 1, 32'h13, 32'h0, 32'h0, 5'd4, 32'h10C);
        step();
        checks++;
        if (wb_wdata !== 32'hFFFFFFA5) begin
            errors++;
            $display("FAIL lb: got %h want ffffffa5", wb_wdata);
        end
        set_op(1, 1, 0, 2'd0, 0, 32'h13, 32'h0, 32'h0, 5'd5, 32'h110);
        step();
        checks++;
        if (wb_wdata !== 32'h000000A5) begin
            errors++;
            $display("FAIL lbu: got %h want 000000a5", wb_wdata);
        end
    endtask

    task automatic test_half();
        set_op(1, 0, 1, 2'd1, 0, 32'h22, 32'h00008001, 32'h0, 5'd0, 32'h114);
        step();
        checks++;
        if (o_dm_byte !== 4'b1100 || o_dm_in !== 32'h80018001) begin
            errors++;
            $display("FAIL sh_drive: got byte=%b in=%h want 1100 80018001", o_dm_byte, o_dm_in);
        end
        set_op(1, 1, 0, 2'd1, 1, 32'h22, 32'h0, 32'h0, 5'd6, 32'h118);
        step();
        checks++;
        if (wb_wdata !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL lh: got %h want ffff8001", wb_wdata);
        end
        set_op(1, 1, 0, 2'd1, 0, 32'h22, 32'h0, 32'h0, 5'd7, 32'h11C);
        step();
        checks++;
        if (wb_wdata !== 32'h00008001) begin
            errors++;
            $display("FAIL lhu: got %h want 00008001", wb_wdata);
        end
    endtask

    task automatic test_misaligned();
        int wc;
        set_op(1, 1, 0, 2'd2, 0, 32'h05, 32'h0, 32'h0, 5'd8, 32'h400);
        step();
        checks++;
        if (o_dm_en !== 1'b0 || exc_valid !== 1'b1 || exc_code !== 5'd4 || exc_badvaddr !== 32'h5 ||
            exc_epc !== 32'h400 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL adel: got en=%b ev=%b code=%0d bad=%h epc=%h wv=%b want 0 1 4 5 400 0",
                     o_dm_en, exc_valid, exc_code, exc_badvaddr, exc_epc, wb_valid);
        end
        idle();
        step();
        checks++;
        if (exc_valid !== 1'b0 || exc_code !== 5'd4 || exc_epc !== 32'h400) begin
            errors++;
            $display("FAIL exc_pulse_hold: got ev=%b code=%0d epc=%h want 0 4 400", exc_valid, exc_code, exc_epc);
        end
        wc = wr_count;
        set_op(1, 0, 1, 2'd1, 0, 32'h07, 32'h0000FFFF, 32'h0, 5'd0, 32'h404);
        step();
        checks++;
        if (exc_valid !== 1'b1 || exc_code !== 5'd5 || exc_badvaddr !== 32'h7 || exc_epc !== 32'h404 ||
            wr_count !== wc || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL ades: got ev=%b code=%0d bad=%h epc=%h writes=%0d wv=%b want 1 5 7 404 %0d 0",
                     exc_valid, exc_code, exc_badvaddr, exc_epc, wr_count, wb_valid, wc);
        end
        set_op(1, 1, 0, 2'd2, 0, 32'h04, 32'h0, 32'h0, 5'd9, 32'h408);
        step();
        checks++;
        if (wb_wdata !== 32'h0) begin
            errors++;
            $display("FAIL ades_mem_untouched: got %h want 00000000", wb_wdata);
        end
    endtask

    task automatic test_stall();
        int wc;
        wc = wr_count;
        set_op(1, 0, 1, 2'd2, 0, 32'h30, 32'h12345678, 32'h0, 5'd10, 32'h500);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (o_dm_en !== 1'b0 || wb_valid !== 1'b0 || wr_count !== wc) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got en=%b wv=%b writes=%0d want 0 0 %0d", c, o_dm_en, wb_valid, wr_count, wc);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wr_count !== wc + 1) begin
            errors++;
            $display("FAIL stall_release: got wv=%b we=%b writes=%0d want 1 0 %0d", wb_valid, wb_we, wr_count, wc + 1);
        end
        set_op(1, 1, 0, 2'd2, 0, 32'h30, 32'h0, 32'h0, 5'd11, 32'h504);
        step();
        checks++;
        if (wb_wdata !== 32'h12345678 || wr_count !== wc + 1) begin
            errors++;
            $display("FAIL stall_single_write: got wd=%h writes=%0d want 12345678 %0d", wb_wdata, wr_count, wc + 1);
        end
    endtask

    task automatic test_flush();
        int wc;
        wc = wr_count;
        set_op(1, 0, 1, 2'd2, 0, 32'h38, 32'hCAFEF00D, 32'h0, 5'd0, 32'h600);
        flush = 1'b1;
        step();
        checks++;
        if (o_dm_en !== 1'b0 || wb_valid !== 1'b0 || wr_count !== wc) begin
            errors++;
            $display("FAIL flush_store: got en=%b wv=%b writes=%0d want 0 0 %0d", o_dm_en, wb_valid, wr_count, wc);
        end
        stall = 1'b1;
        set_op(1, 0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h77, 5'd12, 32'h604);
        step();
        checks++;
        if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got wv=%b we=%b want 0 0", wb_valid, wb_we);
        end
        flush = 1'b0; stall = 1'b0;
        set_op(1, 1, 0, 2'd2, 0, 32'h38, 32'h0, 32'h0, 5'd13, 32'h608);
        step();
        checks++;
        if (wb_wdata !== 32'h0) begin
            errors++;
            $display("FAIL flush_mem_untouched: got %h want 00000000", wb_wdata);
        end
    endtask

    task automatic test_random();
        int kind;
        logic [31:0] a;
        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 2);
            a = 32'($urandom_range(0, 63));
            if (kind == 0) begin
                set_op($urandom_range(0, 7) != 0, 0, 0, 2'd2, 0, a & ~32'h3, $urandom, $urandom,
                       5'($urandom), $urandom & ~32'h3);
            end else begin
                set_op($urandom_range(0, 7) != 0, kind == 1, kind == 2, 2'($urandom), 1'($urandom),
                       a, $urandom, $urandom, 5'($urandom), $urandom & ~32'h3);
            end
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step();
            checks++;
            if (o_dm_en !== e_dm_en || o_dm_byte !== e_dm_byte || o_dm_addr !== e_dm_addr || o_dm_in !== e_dm_in) begin
                errors++;
                $display("FAIL rnd_dm[%0d]: got en=%b byte=%b addr=%h in=%h want %b %b %h %h",
                         it, o_dm_en, o_dm_byte, o_dm_addr, o_dm_in, e_dm_en, e_dm_byte, e_dm_addr, e_dm_in);
            end
            checks++;
            if (wb_valid !== m_valid || wb_we !== m_we || wb_wreg !== m_wreg || wb_wdata !== m_wdata) begin
                errors++;
                $display("FAIL rnd_wb[%0d]: got v=%b we=%b rg=%0d wd=%h want %b %b %0d %h",
                         it, wb_valid, wb_we, wb_wreg, wb_wdata, m_valid, m_we, m_wreg, m_wdata);
            end
            checks++;
            if (exc_valid !== m_exc || exc_code !== m_code || exc_badvaddr !== m_bad || exc_epc !== m_epc) begin
                errors++;
                $display("FAIL rnd_exc[%0d]: got v=%b code=%0d bad=%h epc=%h want %b %0d %h %h",
                         it, exc_valid, exc_code, exc_badvaddr, exc_epc, m_exc, m_code, m_bad, m_epc);
            end
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        set_op(1, 1, 0, 2'd2, 0, 32'h03, 32'h0, 32'h0, 5'd14, 32'h700);
        step();
        set_op(1, 0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h55AA, 5'd15, 32'h704);
        step();
        set_op(1, 0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h1234, 5'd16, 32'h708);
        rst = 1'b1;
        step();
        checks++;
        if ({wb_valid, wb_we, wb_wreg, wb_wdata, exc_valid, exc_code, exc_badvaddr, exc_epc} !== 109'h0) begin
            errors++;
            $display("FAIL reset_midstream: got wv=%b we=%b rg=%0d wd=%h ev=%b code=%0d bad=%h epc=%h want all 0",
                     wb_valid, wb_we, wb_wreg, wb_wdata, exc_valid, exc_code, exc_badvaddr, exc_epc);
        end
        rst = 1'b0;
        idle();
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        m_valid = 0; m_we = 0; m_wreg = 0; m_wdata = 0;
        m_exc = 0; m_code = 0; m_bad = 0; m_epc = 0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_stall();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
